pipe_stage_rv: RTL and testbench
================================

Name: pipe_stage_rv

Overview:
- Parametrised, elastic successor to the fixed inter-stage pipeline registers (IF/ID, ID/EXE, EXE/MEM, MEM/WB).
- One posedge-only register stage with valid/ready handshake, optional 2-entry skid buffer, synchronous flush and bubble gating of control bits.
- A flushed or empty stage presents a NOP downstream.
- Sits between any two pipeline stages; payload split into a control field (zeroed on bubble) and a data field.

Parameters:
- DATA_W, 102, data payload width (EXE/MEM default: PC 32 + zero 1 + ALU 32 + operand B 32 + rd 5).
- CTRL_W, 5, control payload width (WB 2 + MEM 3); forced to 0 whenever out_valid=0.
- SKID, 1, 1 = 2-entry skid buffer with registered in_ready; 0 = single entry with combinational in_ready.
- CNT_W, 8, width of the saturating flush-drop counter.

Ports:
- clk  in  1  clock, all state updates on rising edge.
- rst  in  1  synchronous reset, active-high.
- in_valid  in  1  upstream beat valid.
- in_ready  out  1  stage can accept a beat this cycle.
- in_ctrl  in  CTRL_W  upstream control bits.
- in_data  in  DATA_W  upstream data bits.
- flush  in  1  synchronous kill of all held beats, e.g. branch taken.
- out_valid  out  1  downstream beat valid.
- out_ready  in  1  downstream accepts the beat.
- out_ctrl  out  CTRL_W  held control bits, 0 when out_valid=0.
- out_data  out  DATA_W  held data bits.
- occupancy  out  2  number of held beats (0..2; max 1 when SKID=0).
- flush_drop_cnt  out  CNT_W  saturating count of beats discarded by flush.

Behaviour:
- Single clock (clk); reset synchronous, active-high (rst); posedge only, no negedge logic.
- Definitions: accept = in_valid & in_ready; drain = out_valid & out_ready.
- Reset (rst=1 at an edge) forces:
  - state EMPTY, out_valid=0, occupancy=0, flush_drop_cnt=0.
  - main and skid registers cleared to 0, so out_ctrl=0 and out_data=0.
  - in_ready=1 from the first cycle after reset.
  - An input beat presented during a reset cycle is discarded and not counted.
- States (occupancy): EMPTY(0), ONE(1, main full), TWO(2, main+skid full; SKID=1 only).
- out_valid = (state != EMPTY); out_ctrl = out_valid ? main_ctrl : 0; out_data = main_data, holding its last value when invalid.
- in_ready:
  - SKID=1: registered, equals (next_state != TWO).
  - SKID=0: combinational, equals !out_valid | out_ready.
- Transitions when flush=0:
  - EMPTY: accept -> ONE, main<=in.
  - ONE: accept&drain -> ONE, main<=in.
  - ONE: accept&!drain -> TWO, skid<=in (SKID=1 only).
  - ONE: !accept&drain -> EMPTY.
  - ONE: neither -> hold.
  - TWO: drain -> ONE, main<=skid. No accept is possible (in_ready=0).
  - TWO: !drain -> hold.
- Stability: while out_valid & !out_ready, out_ctrl/out_data/out_valid remain unchanged.
- Latency: in to out 1 cycle. Throughput 1 beat/cycle sustained when out_ready=1. Order is strictly FIFO.
- Flush (flush=1 at an edge, rst=0):
  - Next state EMPTY; out_valid=0 next cycle; out_ctrl=0 next cycle; in_ready=1 next cycle.
  - A beat drained in the flush cycle counts as delivered.
  - A beat accepted in the flush cycle is discarded.
  - flush_drop_cnt += (occupancy - drain) + accept, saturating at 2^CNT_W-1 with no wrap.
- Priority: rst > flush > normal transitions.
- Flush asserted on consecutive cycles: each cycle evaluated independently; an empty stage adds 0 unless a beat is accepted that cycle.
- No combinational path from in_valid to out_valid. In SKID=1 mode, no combinational path from out_ready to in_ready.

Test Plan:
- Reset, then in_valid=1, in_ctrl=5'h1B, in_data=X, out_ready=1 -> out_valid=1 with out_ctrl=5'h1B, out_data=X one cycle later; occupancy=1; in_ready=1.
- SKID=1 stream A,B,C with out_ready=0 from cycle 1 -> A held on output; B in skid; in_ready=0; occupancy=2; C held upstream. Raise out_ready -> A, B, C delivered in order on consecutive cycles with no gap or duplicate.
- SKID=0, same stall -> occupancy never exceeds 1; in_ready follows out_ready combinationally while full; order preserved.
- Occupancy=2, out_ready=0, pulse flush one cycle -> out_valid=0 and out_ctrl=0 next cycle; flush_drop_cnt=2; in_ready=1.
- Flush in the same cycle as accept, with occupancy=1 and drain=1 -> flush_drop_cnt increments by 1; output empty next cycle.
- CNT_W=2, four flushes each dropping 2 beats -> flush_drop_cnt saturates at 3. rst mid-stream (occupancy=2) -> all outputs return to reset values next cycle.

Source files
------------

// File: rtl/pipe_stage_rv.sv
// Elastic pipeline register stage: valid/ready handshake, optional 2-entry skid
// buffer, synchronous flush with a saturating drop counter, control bits zeroed on bubbles.
module pipe_stage_rv #(
  parameter int DATA_W = 102,
  parameter int CTRL_W = 5,
  parameter int SKID   = 1,
  parameter int CNT_W  = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [CTRL_W-1:0] in_ctrl,
  input  logic [DATA_W-1:0] in_data,
  input  logic              flush,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [DATA_W-1:0] out_data,
  output logic [1:0]        occupancy,
  output logic [CNT_W-1:0]  flush_drop_cnt
);

  // Handshake: a beat moves on a side when valid and ready are both high at a
  // rising edge; a held beat (valid & !ready) keeps valid and payload stable.

  // State encoding equals the number of held beats, so occupancy doubles as
  // the observable FSM state.
  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_TWO   = 2'd2
  } state_e;

  localparam logic [CNT_W:0] CNT_MAX = {1'b0, {CNT_W{1'b1}}};

  state_e            state_q, state_d;
  logic [CTRL_W-1:0] main_ctrl_q, main_ctrl_d;
  logic [DATA_W-1:0] main_data_q, main_data_d;
  logic [CTRL_W-1:0] skid_ctrl_q, skid_ctrl_d;
  logic [DATA_W-1:0] skid_data_q, skid_data_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;

  logic              accept;
  logic              drain;
  logic [1:0]        occ;
  logic [1:0]        drop;
  logic [CNT_W:0]    cnt_sum;

  assign occ       = state_q;
  assign out_valid = (state_q != ST_EMPTY);
  assign accept    = in_valid & in_ready;
  assign drain     = out_valid & out_ready;

  // Beats lost to a flush: everything held except a beat leaving this cycle,
  // plus a beat arriving this cycle. Never exceeds 2.
  assign drop    = occ - {1'b0, drain} + {1'b0, accept};
  assign cnt_sum = {1'b0, cnt_q} + {{(CNT_W - 1){1'b0}}, drop};

  always_comb begin
    state_d     = state_q;
    main_ctrl_d = main_ctrl_q;
    main_data_d = main_data_q;
    skid_ctrl_d = skid_ctrl_q;
    skid_data_d = skid_data_q;
    cnt_d       = cnt_q;
    if (flush) begin
      state_d = ST_EMPTY;
      cnt_d   = (cnt_sum > CNT_MAX) ? CNT_MAX[CNT_W-1:0] : cnt_sum[CNT_W-1:0];
    end else begin
      case (state_q)
        ST_EMPTY: begin
          if (accept) begin
            state_d     = ST_ONE;
            main_ctrl_d = in_ctrl;
            main_data_d = in_data;
          end
        end
        ST_ONE: begin
          if (accept && drain) begin
            main_ctrl_d = in_ctrl;
            main_data_d = in_data;
          end else if (accept && (SKID != 0)) begin
            state_d     = ST_TWO;
            skid_ctrl_d = in_ctrl;
            skid_data_d = in_data;
          end else if (drain) begin
            state_d = ST_EMPTY;
          end
        end
        ST_TWO: begin
          if (drain) begin
            state_d     = ST_ONE;
            main_ctrl_d = skid_ctrl_q;
            main_data_d = skid_data_q;
          end
        end
        default: state_d = ST_EMPTY;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_EMPTY;
      main_ctrl_q <= '0;
      main_data_q <= '0;
      skid_ctrl_q <= '0;
      skid_data_q <= '0;
      cnt_q       <= '0;
    end else begin
      state_q     <= state_d;
      main_ctrl_q <= main_ctrl_d;
      main_data_q <= main_data_d;
      skid_ctrl_q <= skid_ctrl_d;
      skid_data_q <= skid_data_d;
      cnt_q       <= cnt_d;
    end
  end

  generate
    if (SKID != 0) begin : g_skid
      // Registered ready breaks the out_ready -> in_ready path; the skid entry
      // absorbs the beat that arrives while ready is still catching up.
      logic in_ready_q;
      always_ff @(posedge clk) begin
        if (rst) begin
          in_ready_q <= 1'b1;
        end else begin
          in_ready_q <= (state_d != ST_TWO);
        end
      end
      assign in_ready = in_ready_q;
    end else begin : g_noskid
      assign in_ready = !out_valid | out_ready;
    end
  endgenerate

  assign out_ctrl       = out_valid ? main_ctrl_q : '0;
  assign out_data       = main_data_q;
  assign occupancy      = occ;
  assign flush_drop_cnt = cnt_q;

endmodule

// File: tb/tb_pipe_stage_rv.sv
// Bench for pipe_stage_rv: three instances (skid, no-skid, 2-bit counter) checked
// against a queue-based model of held beats plus directed scenario checks.
module tb_pipe_stage_rv;

  typedef struct {
    logic [4:0]   c;
    logic [101:0] d;
  } beat_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic [2:0]          rst_s, iv_s, fl_s, or_s;
  logic [2:0][4:0]     ic_s;
  logic [2:0][101:0]   id_s;
  wire  [2:0]          ir_s, ov_s;
  wire  [2:0][4:0]     oc_s;
  wire  [2:0][101:0]   od_s;
  wire  [2:0][1:0]     occ_s;
  wire  [2:0][7:0]     cnt_s;
  wire  [1:0]          cnt2;

  assign cnt_s[2] = {6'd0, cnt2};

  pipe_stage_rv #(.DATA_W(102), .CTRL_W(5), .SKID(1), .CNT_W(8)) u_skid (
    .clk(clk), .rst(rst_s[0]), .in_valid(iv_s[0]), .in_ready(ir_s[0]),
    .in_ctrl(ic_s[0]), .in_data(id_s[0]), .flush(fl_s[0]), .out_valid(ov_s[0]),
    .out_ready(or_s[0]), .out_ctrl(oc_s[0]), .out_data(od_s[0]),
    .occupancy(occ_s[0]), .flush_drop_cnt(cnt_s[0])
  );

  pipe_stage_rv #(.DATA_W(102), .CTRL_W(5), .SKID(0), .CNT_W(8)) u_noskid (
    .clk(clk), .rst(rst_s[1]), .in_valid(iv_s[1]), .in_ready(ir_s[1]),
    .in_ctrl(ic_s[1]), .in_data(id_s[1]), .flush(fl_s[1]), .out_valid(ov_s[1]),
    .out_ready(or_s[1]), .out_ctrl(oc_s[1]), .out_data(od_s[1]),
    .occupancy(occ_s[1]), .flush_drop_cnt(cnt_s[1])
  );

  pipe_stage_rv #(.DATA_W(102), .CTRL_W(5), .SKID(1), .CNT_W(2)) u_cnt2 (
    .clk(clk), .rst(rst_s[2]), .in_valid(iv_s[2]), .in_ready(ir_s[2]),
    .in_ctrl(ic_s[2]), .in_data(id_s[2]), .flush(fl_s[2]), .out_valid(ov_s[2]),
    .out_ready(or_s[2]), .out_ctrl(oc_s[2]), .out_data(od_s[2]),
    .occupancy(occ_s[2]), .flush_drop_cnt(cnt2)
  );

  int errors = 0;
  int checks = 0;

  // Reference model: the held beats in arrival order, the last head data,
  // and the drop count.
  beat_t        mq[$];
  logic [101:0] m_main;
  int           m_cnt;

  int           cur_k;
  logic         cur_r, cur_iv, cur_fl, cur_or;
  logic [4:0]   cur_c;
  logic [101:0] cur_d;
  logic         last_acc;

  localparam logic [118:0] RESET_VEC = {1'b0, 2'd0, 5'd0, 1'b1, 8'd0, 102'd0};

  function automatic logic [101:0] rnd_data();
    logic [127:0] t;
    t = {$urandom(), $urandom(), $urandom(), $urandom()};
    return t[101:0];
  endfunction

  function automatic logic [118:0] act_vec(int k);
    return {ov_s[k], occ_s[k], oc_s[k], ir_s[k], cnt_s[k], od_s[k]};
  endfunction

  function automatic logic [118:0] exp_vec(int k, logic ordy);
    logic       v;
    logic [4:0] c;
    logic       rdy;
    int         sz;
    sz  = mq.size();
    v   = (sz != 0);
    c   = 5'd0;
    if (v) c = mq[0].c;
    rdy = (k != 1) ? (sz < 2) : (sz == 0 || ordy);
    return {v, 2'(sz), c, rdy, 8'(m_cnt), m_main};
  endfunction

  task automatic drive(int k, logic r, logic iv, logic [4:0] c, logic [101:0] d,
                       logic fl, logic ordy);
    rst_s[k] = r;  iv_s[k] = iv;  ic_s[k] = c;  id_s[k] = d;
    fl_s[k]  = fl; or_s[k] = ordy;
    cur_k = k; cur_r = r; cur_iv = iv; cur_c = c; cur_d = d; cur_fl = fl; cur_or = ordy;
    #1;
  endtask

  task automatic advance();
    int    sz, drop, cmax;
    logic  rdy, acc, drn;
    beat_t b;
    sz   = mq.size();
    rdy  = (cur_k != 1) ? (sz < 2) : (sz == 0 || cur_or);
    acc  = cur_iv && rdy;
    drn  = (sz > 0) && cur_or;
    cmax = (cur_k == 2) ? 3 : 255;
    @(posedge clk);
    last_acc = acc && !cur_r;
    if (cur_r) begin
      mq.delete();
      m_main = '0;
      m_cnt  = 0;
    end else if (cur_fl) begin
      drop  = sz - int'(drn) + int'(acc);
      m_cnt = (m_cnt + drop > cmax) ? cmax : m_cnt + drop;
      mq.delete();
    end else begin
      if (drn) void'(mq.pop_front());
      if (acc) begin
        b.c = cur_c;
        b.d = cur_d;
        mq.push_back(b);
      end
      if (mq.size() > 0) m_main = mq[0].d;
    end
    @(negedge clk);
  endtask

  task automatic test_reset();
    logic [101:0] d;
    for (int i = 0; i < 4; i++) begin
      d = rnd_data();
      // cycle 0 loads a beat, cycle 1 holds it, cycle 2 resets with a beat offered
      drive(0, i == 2, i < 3, 5'($urandom_range(0, 31)), d, 1'b0, 1'b0);
      checks++;
      if (act_vec(0) !== exp_vec(0, 1'b0)) begin
        errors++;
        $display("FAIL reset_model cyc=%0d got=%h exp=%h", i, act_vec(0), exp_vec(0, 1'b0));
      end
      advance();
    end
    drive(0, 1'b0, 1'b0, 5'd0, '0, 1'b0, 1'b0);
    checks++;
    if (act_vec(0) !== RESET_VEC) begin
      errors++;
      $display("FAIL reset_values got=%h exp=%h", act_vec(0), RESET_VEC);
    end
  endtask

  task automatic test_basic();
    logic [101:0] x;
    x = rnd_data();
    drive(0, 1'b1, 1'b0, 5'd0, '0, 1'b0, 1'b1);
    advance();
    for (int i = 0; i < 3; i++) begin
      drive(0, 1'b0, i == 0, 5'h1B, x, 1'b0, 1'b1);
      checks++;
      if (act_vec(0) !== exp_vec(0, 1'b1)) begin
        errors++;
        $display("FAIL basic_model cyc=%0d got=%h exp=%h", i, act_vec(0), exp_vec(0, 1'b1));
      end
      if (i == 1) begin
        checks++;
        if ({ov_s[0], oc_s[0], od_s[0], occ_s[0], ir_s[0]} !== {1'b1, 5'h1B, x, 2'd1, 1'b1}) begin
          errors++;
          $display("FAIL basic_latency got=%h exp=%h",
                   {ov_s[0], oc_s[0], od_s[0], occ_s[0], ir_s[0]}, {1'b1, 5'h1B, x, 2'd1, 1'b1});
        end
      end
      advance();
    end
  endtask

  task automatic test_stall(int k);
    logic [106:0] exp_q[$];
    beat_t        pend[$];
    beat_t        b;
    logic         ordy;
    int           first_cyc, n_del;
    drive(k, 1'b1, 1'b0, 5'd0, '0, 1'b0, 1'b0);
    advance();
    for (int i = 0; i < 3; i++) begin
      b.c = 5'(i + 1);
      b.d = rnd_data();
      pend.push_back(b);
      exp_q.push_back({b.c, b.d});
    end
    first_cyc = -1;
    n_del = 0;
    for (int i = 0; i < 8; i++) begin
      ordy = (i >= 3);
      b.c = 5'd0;
      b.d = '0;
      if (pend.size() > 0) b = pend[0];
      drive(k, 1'b0, pend.size() > 0, b.c, b.d, 1'b0, ordy);
      checks++;
      if (act_vec(k) !== exp_vec(k, ordy)) begin
        errors++;
        $display("FAIL stall_model k=%0d cyc=%0d got=%h exp=%h", k, i, act_vec(k), exp_vec(k, ordy));
      end
      if (i == 2) begin
        checks++;
        if ({occ_s[k], ir_s[k]} !== {(k == 1) ? 2'd1 : 2'd2, 1'b0}) begin
          errors++;
          $display("FAIL stall_full k=%0d got occ=%0d rdy=%b", k, occ_s[k], ir_s[k]);
        end
      end
      if (ov_s[k] && ordy) begin
        if (first_cyc < 0) first_cyc = i;
        checks++;
        if (exp_q.size() == 0 || {oc_s[k], od_s[k]} !== exp_q[0] || i != first_cyc + n_del) begin
          errors++;
          $display("FAIL stall_order k=%0d cyc=%0d got=%h", k, i, {oc_s[k], od_s[k]});
        end
        if (exp_q.size() > 0) void'(exp_q.pop_front());
        n_del++;
      end
      advance();
      if (last_acc) void'(pend.pop_front());
    end
    checks++;
    if (n_del != 3 || exp_q.size() != 0) begin
      errors++;
      $display("FAIL stall_count k=%0d got=%0d required=3", k, n_del);
    end
  endtask

  task automatic test_flush_two();
    drive(0, 1'b1, 1'b0, 5'd0, '0, 1'b0, 1'b0);
    advance();
    for (int i = 0; i < 3; i++) begin
      drive(0, 1'b0, i < 2, 5'(i + 7), rnd_data(), i == 2, 1'b0);
      checks++;
      if (act_vec(0) !== exp_vec(0, 1'b0)) begin
        errors++;
        $display("FAIL flush2_model cyc=%0d got=%h exp=%h", i, act_vec(0), exp_vec(0, 1'b0));
      end
      advance();
    end
    drive(0, 1'b0, 1'b0, 5'd0, '0, 1'b0, 1'b0);
    checks++;
    if ({ov_s[0], oc_s[0], ir_s[0], occ_s[0], cnt_s[0]} !== {1'b0, 5'd0, 1'b1, 2'd0, 8'd2}) begin
      errors++;
      $display("FAIL flush2_result got=%h exp=%h",
               {ov_s[0], oc_s[0], ir_s[0], occ_s[0], cnt_s[0]}, {1'b0, 5'd0, 1'b1, 2'd0, 8'd2});
    end
  endtask

  task automatic test_flush_accept();
    drive(0, 1'b1, 1'b0, 5'd0, '0, 1'b0, 1'b1);
    advance();
    for (int i = 0; i < 2; i++) begin
      drive(0, 1'b0, 1'b1, 5'(i + 3), rnd_data(), i == 1, 1'b1);
      checks++;
      if (act_vec(0) !== exp_vec(0, 1'b1)) begin
        errors++;
        $display("FAIL flushacc_model cyc=%0d got=%h exp=%h", i, act_vec(0), exp_vec(0, 1'b1));
      end
      advance();
    end
    drive(0, 1'b0, 1'b0, 5'd0, '0, 1'b0, 1'b1);
    checks++;
    if ({ov_s[0], oc_s[0], occ_s[0], cnt_s[0]} !== {1'b0, 5'd0, 2'd0, 8'd1}) begin
      errors++;
      $display("FAIL flushacc_result got=%h exp=%h",
               {ov_s[0], oc_s[0], occ_s[0], cnt_s[0]}, {1'b0, 5'd0, 2'd0, 8'd1});
    end
  endtask

  task automatic test_saturate();
    drive(2, 1'b1, 1'b0, 5'd0, '0, 1'b0, 1'b0);
    advance();
    // four rounds of fill-two-then-flush, then fill two and reset
    for (int i = 0; i < 15; i++) begin
      drive(2, i == 14, (i % 3) != 2, 5'($urandom_range(1, 31)), rnd_data(),
            (i % 3) == 2 && i < 12, 1'b0);
      checks++;
      if (act_vec(2) !== exp_vec(2, 1'b0)) begin
        errors++;
        $display("FAIL sat_model cyc=%0d got=%h exp=%h", i, act_vec(2), exp_vec(2, 1'b0));
      end
      if (i == 12) begin
        checks++;
        if (cnt_s[2] !== 8'd3) begin
          errors++;
          $display("FAIL sat_count got=%0d required=3", cnt_s[2]);
        end
      end
      advance();
    end
    drive(2, 1'b0, 1'b0, 5'd0, '0, 1'b0, 1'b0);
    checks++;
    if (act_vec(2) !== RESET_VEC) begin
      errors++;
      $display("FAIL sat_midreset got=%h exp=%h", act_vec(2), RESET_VEC);
    end
  endtask

  task automatic test_random(int k);
    logic r, iv, fl, ordy;
    drive(k, 1'b1, 1'b0, 5'd0, '0, 1'b0, 1'b0);
    advance();
    for (int i = 0; i < 400; i++) begin
      r    = ($urandom_range(0, 63) == 0);
      fl   = ($urandom_range(0, 11) == 0);
      iv   = ($urandom_range(0, 9) < 7);
      ordy = ($urandom_range(0, 9) < 6);
      drive(k, r, iv, 5'($urandom_range(0, 31)), rnd_data(), fl, ordy);
      checks++;
      if (act_vec(k) !== exp_vec(k, ordy)) begin
        errors++;
        $display("FAIL random_model k=%0d cyc=%0d got=%h exp=%h", k, i, act_vec(k), exp_vec(k, ordy));
      end
      advance();
    end
  endtask

  initial begin
    rst_s = 3'b111; iv_s = '0; fl_s = '0; or_s = '0; ic_s = '0; id_s = '0;
    cur_k = 0; cur_r = 1'b1; cur_iv = 1'b0; cur_fl = 1'b0; cur_or = 1'b0;
    cur_c = '0; cur_d = '0; last_acc = 1'b0;
    mq.delete(); m_main = '0; m_cnt = 0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_s = 3'b000;
    test_reset();
    test_basic();
    test_stall(0);
    test_stall(1);
    test_flush_two();
    test_flush_accept();
    test_saturate();
    test_random(0);
    test_random(1);
    test_random(2);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
